// File: rtl/dp_floating_divider.sv
// dp_floating_divider
//   Iterative IEEE-754 binary64 divider. One restoring mantissa step per cycle.
//   Rounding is truncation. Denormal inputs are treated as zero. Results that
//   overflow saturate to infinity, and results that underflow flush to zero.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. The input side is ready only in IDLE. The output holds quo
//   stable with out_valid high until out_ready is seen.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   a, b       : dividend / divisor, captured on the accept edge
//   in_valid   : operand pair valid
//   in_ready   : divider idle and able to accept
//   quo        : registered quotient
//   out_valid  : quotient available
//   out_ready  : consumer takes the quotient
module dp_floating_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] quo,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
    state_t state, state_next;

    logic        sign;
    logic [10:0] ea, eb;
    logic [52:0] mb;
    logic [53:0] r;
    logic [53:0] q;
    logic [5:0]  cnt;

    // Operand classification
    logic [10:0] a_exp, b_exp;
    logic        a_frac_nz, b_frac_nz;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        special;
    logic [63:0] special_quo;
    logic        s_in;

    assign a_exp     = a[62:52];
    assign b_exp     = b[62:52];
    assign a_frac_nz = |a[51:0];
    assign b_frac_nz = |b[51:0];
    assign a_zero    = (a_exp == 11'd0);    // denormals count as zero
    assign b_zero    = (b_exp == 11'd0);
    assign a_inf     = (a_exp == 11'h7FF) && !a_frac_nz;
    assign b_inf     = (b_exp == 11'h7FF) && !b_frac_nz;
    assign a_nan     = (a_exp == 11'h7FF) && a_frac_nz;
    assign b_nan     = (b_exp == 11'h7FF) && b_frac_nz;
    assign s_in      = a[63] ^ b[63];
    assign special   = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

    always_comb begin
        special_quo = {s_in, 63'h0};
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            special_quo = 64'h7FF8000000000000;
        else if (a_inf || b_zero)
            special_quo = {s_in, 11'h7FF, 52'h0};
        else
            special_quo = {s_in, 63'h0};
    end

    // Restoring step. r stays below 2*mb, so it always fits in 54 bits.
    logic        r_ge;
    logic [53:0] r_sub;
    logic [53:0] r_next;

    assign r_ge   = (r >= {1'b0, mb});
    assign r_sub  = r - {1'b0, mb};
    assign r_next = r_ge ? {r_sub[52:0], 1'b0} : {r[52:0], 1'b0};

    // Normalisation. q[53] set means the mantissa ratio is in [1,2).
    logic signed [12:0] e_calc;
    logic [51:0]        frac;
    logic [63:0]        norm_quo;

    always_comb begin
        e_calc = $signed({2'b00, ea}) - $signed({2'b00, eb})
                 + (q[53] ? 13'sd1023 : 13'sd1022);
        frac   = q[53] ? q[52:1] : q[51:0];
        if (e_calc >= 13'sd2047)
            norm_quo = {sign, 11'h7FF, 52'h0};
        else if (e_calc <= 13'sd0)
            norm_quo = {sign, 63'h0};
        else
            norm_quo = {sign, e_calc[10:0], frac};
    end

    assign in_ready = (state == IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = special ? DONE : DIV;
            DIV:  if (cnt == 6'd0) state_next = NORM;
            NORM: state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sign      <= 1'b0;
            ea        <= '0;
            eb        <= '0;
            mb        <= '0;
            r         <= '0;
            q         <= '0;
            cnt       <= '0;
            quo       <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= s_in;
                        ea   <= a_exp;
                        eb   <= b_exp;
                        mb   <= {1'b1, b[51:0]};
                        r    <= {2'b01, a[51:0]};
                        q    <= '0;
                        cnt  <= 6'd53;
                        if (special) begin
                            quo       <= special_quo;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    r   <= r_next;
                    q   <= {q[52:0], r_ge};
                    cnt <= cnt - 6'd1;
                end
                NORM: begin
                    quo       <= norm_quo;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_floating_divider.sv
// tb_dp_floating_divider
//   Directed-vector bench for dp_floating_divider. Expected quotients and
//   latencies are hand-computed constants.
//   Latency is counted as the number of rising edges after the accept edge
//   before out_valid is visible. The normal path sets out_valid on E55, so
//   its latency is 55. A special case sets out_valid on the accept edge
//   itself, so its latency is 0.
module tb_dp_floating_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a, b;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] quo;
    logic        out_valid;
    logic        out_ready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dp_floating_divider dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quo       (quo),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one operand pair, measure latency, check the result, then complete the handshake.
    task automatic run_op(input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] exp_q, input int exp_lat,
                          input string name);
        int lat;
        int budget;
        budget = 0;
        while (!in_ready && budget < 200) begin
            tick();
            budget++;
        end
        vectors++;
        if (!in_ready) begin
            miscompares++;
            $display("FAIL %s in_ready_timeout: in_ready=%0b required 1", name, in_ready);
            return;
        end
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();                         // accept edge E0
        in_valid = 1'b0;
        a = 64'h0;
        b = 64'h0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        vectors++;
        if (quo !== exp_q) begin
            miscompares++;
            $display("FAIL %s quo: got %h required %h", name, quo, exp_q);
        end
        out_ready = 1'b1;
        tick();                         // output handshake edge
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s handshake: out_valid=%0b in_ready=%0b required 0/1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        vectors++;
        if (quo !== 64'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: quo=%h out_valid=%0b in_ready=%0b required 0/0/1",
                     quo, out_valid, in_ready);
        end
    endtask

    task automatic test_abort();
        int seen;
        a = 64'h4018000000000000;
        b = 64'h4000000000000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_after_reset: in_ready=%0b out_valid=%0b required 1/0",
                     in_ready, out_valid);
        end
        seen = 0;
        repeat (70) begin
            tick();
            if (out_valid) seen = 1;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL abort_no_output: out_valid seen=%0d required 0", seen);
        end
    endtask

    task automatic test_normal();
        run_op(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 55, "six_div_two");
        run_op(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 55, "one_div_three");
        run_op(64'hBFF0000000000000, 64'h4000000000000000, 64'hBFE0000000000000, 55, "neg_one_div_two");
    endtask

    task automatic test_specials();
        run_op(64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 0, "one_div_zero");
        run_op(64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 0, "zero_div_zero");
        run_op(64'h8000000000000000, 64'h4000000000000000, 64'h8000000000000000, 0, "negzero_div_two");
        run_op(64'h4000000000000000, 64'h7FF0000000000000, 64'h0000000000000000, 0, "two_div_inf");
        run_op(64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 0, "inf_div_neginf");
        run_op(64'h7FF8000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 0, "nan_div_one");
        run_op(64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 0, "neginf_div_two");
        run_op(64'h0000000000000001, 64'h3FF0000000000000, 64'h0000000000000000, 0, "denorm_div_one");
    endtask

    task automatic test_range();
        run_op(64'h7FE0000000000000, 64'h3FE0000000000000, 64'h7FF0000000000000, 55, "overflow");
        run_op(64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 55, "underflow_flush");
    endtask

    task automatic test_backpressure();
        int lat;
        logic [63:0] held;
        logic stable;
        a = 64'h4018000000000000;
        b = 64'h4000000000000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        vectors++;
        if (quo !== 64'h4008000000000000) begin
            miscompares++;
            $display("FAIL bp_first_quo: got %h required 4008000000000000", quo);
        end
        held = quo;
        a = 64'h3FF0000000000000;
        b = 64'h4008000000000000;
        in_valid = 1'b1;
        out_ready = 1'b0;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (quo !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        vectors++;
        if (stable !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold: quo=%h in_ready=%0b out_valid=%0b required %h/0/1",
                     quo, in_ready, out_valid, held);
        end
        out_ready = 1'b1;
        tick();                         // handshake edge: no accept here
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1/0",
                     in_ready, out_valid);
        end
        tick();                         // next pair accepted here
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_next_accept: in_ready=%0b required 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        vectors++;
        if (quo !== 64'h3FD5555555555555 || lat !== 55) begin
            miscompares++;
            $display("FAIL bp_next_result: quo=%h lat=%0d required 3fd5555555555555/55", quo, lat);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a = 64'h0;
        b = 64'h0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_normal();
        test_specials();
        test_range();
        test_abort();
        test_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
